// File: rtl/ntt_bu_reduce_if.sv
// Handshake bus between the NTT butterfly, the reduction stage and its consumer.
interface ntt_bu_reduce_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    valid_i;
  logic                    ready_o;
  logic [2*DATA_WIDTH-1:0] ntt_data1_i;
  logic [2*DATA_WIDTH-1:0] ntt_data2_i;
  logic                    valid_o;
  logic                    ready_i;
  logic [DATA_WIDTH-1:0]   data1_o;
  logic [DATA_WIDTH-1:0]   data2_o;
  logic                    last_o;

  // A transfer happens on a rising edge where valid and ready are both high; the
  // sender holds valid and payload until then; ready never depends on valid.
  modport slave (
    input  valid_i, ntt_data1_i, ntt_data2_i, ready_i,
    output ready_o, valid_o, data1_o, data2_o, last_o
  );
  modport master (
    output valid_i, ntt_data1_i, ntt_data2_i, ready_i,
    input  ready_o, valid_o, data1_o, data2_o, last_o
  );
endinterface

// File: rtl/ntt_bu_reduce.sv
// Three-stage Barrett reduction of the butterfly's two signed results to [0, Q),
// with a pair counter that flags the last pair of each NTT layer.
module ntt_bu_reduce #(
  parameter int DATA_WIDTH = 32,
  parameter int Val_Q      = 8380417,
  parameter int NUM_PAIRS  = 128
) (
  input  logic           clk_i,
  input  logic           reset_ni,
  ntt_bu_reduce_if.slave bus
);
  localparam int XW = 2 * DATA_WIDTH;
  localparam int K  = 4 * DATA_WIDTH;
  localparam int PW = XW + K + 1;
  localparam int CW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam logic [K:0]    TWO_K = {1'b1, {K{1'b0}}};
  localparam logic [K:0]    M     = TWO_K / (K + 1)'(Val_Q);
  localparam logic [XW-1:0] Q_X   = XW'(Val_Q);
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_PAIRS - 1);

  function automatic logic [XW-1:0] abs_val(input logic [XW-1:0] x);
    return x[XW-1] ? (~x + 1'b1) : x;
  endfunction

  // q never exceeds |x|/Q, so it always fits back into XW bits.
  function automatic logic [XW-1:0] barrett_q(input logic [XW-1:0] mag);
    logic [PW-1:0] prod;
    prod = PW'(mag) * PW'(M);
    return XW'(prod >> K);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] finish_lane(input logic neg,
                                                        input logic [XW-1:0] mag,
                                                        input logic [XW-1:0] q);
    logic [XW-1:0] r;
    r = mag - q * Q_X;
    if (r >= Q_X) r = r - Q_X;
    if (r >= Q_X) r = r - Q_X;
    if (neg && (r != '0)) r = Q_X - r;
    return DATA_WIDTH'(r);
  endfunction

  logic                     advance;
  logic [CW-1:0]            cnt;
  logic                     last_in;
  logic [1:0][XW-1:0]       x_in;

  logic                     s1_valid, s1_last;
  logic [1:0]               s1_neg;
  logic [1:0][XW-1:0]       s1_mag;

  logic                     s2_valid, s2_last;
  logic [1:0]               s2_neg;
  logic [1:0][XW-1:0]       s2_mag;
  logic [1:0][XW-1:0]       s2_q;

  logic                     s3_valid, s3_last;
  logic [1:0][DATA_WIDTH-1:0] s3_data;

  assign x_in    = {bus.ntt_data2_i, bus.ntt_data1_i};
  assign last_in = (cnt == CNT_LAST);
  assign advance = bus.ready_i || !s3_valid;

  assign bus.ready_o = advance;
  assign bus.valid_o = s3_valid;
  assign bus.last_o  = s3_last;
  assign bus.data1_o = s3_data[0];
  assign bus.data2_o = s3_data[1];

  // The whole pipe moves as one; bubbles shift along with real pairs.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt      <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_neg   <= '0;
      s1_mag   <= '0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_neg   <= '0;
      s2_mag   <= '0;
      s2_q     <= '0;
      s3_valid <= 1'b0;
      s3_last  <= 1'b0;
      s3_data  <= '0;
    end else if (advance) begin
      if (bus.valid_i) cnt <= last_in ? '0 : cnt + 1'b1;
      s1_valid <= bus.valid_i;
      s1_last  <= bus.valid_i && last_in;
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_neg   <= s1_neg;
      s2_mag   <= s1_mag;
      s3_valid <= s2_valid;
      s3_last  <= s2_last;
      for (int i = 0; i < 2; i++) begin
        s1_neg[i]  <= x_in[i][XW-1];
        s1_mag[i]  <= abs_val(x_in[i]);
        s2_q[i]    <= barrett_q(s1_mag[i]);
        s3_data[i] <= finish_lane(s2_neg[i], s2_mag[i], s2_q[i]);
      end
    end
  end
endmodule

// File: tb/tb_ntt_bu_reduce.sv
// Bench for ntt_bu_reduce: table vectors, throughput, backpressure and a long
// random run with a mid-stream reset, all checked against a % based golden model.
module tb_ntt_bu_reduce;
  localparam int     DW = 32;
  localparam int     NP = 128;
  localparam longint Q  = 8380417;
  localparam logic [63:0] XMAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] XMIN = 64'h8000_0000_0000_0000;

  typedef struct {
    logic [63:0]   x1;
    logic [63:0]   x2;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ntt_bu_reduce_if #(.DATA_WIDTH(DW)) bus ();

  ntt_bu_reduce #(.DATA_WIDTH(DW), .Val_Q(8380417), .NUM_PAIRS(NP)) dut (
    .clk_i   (clk),
    .reset_ni(rst_n),
    .bus     (bus)
  );

  logic [2*DW:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  int pair_cnt = 0;
  int accepted = 0;
  int out_cnt = 0;
  int last_cnt = 0;
  int cyc = 0;
  logic hold_pend = 1'b0;
  logic [2*DW+1:0] hold_val;
  logic smp_valid, smp_ready;
  vec_t tbl[8];
  logic [63:0] bnd[7];

  function automatic logic [DW-1:0] gold(input logic [63:0] x);
    longint s, r;
    s = x;
    r = s % Q;
    if (r < 0) r = r + Q;
    return DW'(r);
  endfunction

  function automatic logic [63:0] rand_x();
    case ($urandom_range(0, 4))
      0:       return {$urandom(), $urandom()};
      1:       return 64'($urandom_range(0, 4 * 8380417));
      2:       return -64'($urandom_range(0, 4 * 8380417));
      3:       return {1'b1, 31'($urandom()), $urandom()};
      default: return bnd[$urandom_range(0, 6)];
    endcase
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock: drive at the falling edge, sample 1 ns later; the handshake
  // decided here is the one that the next rising edge performs.
  task automatic step(input logic v, input logic [63:0] x1, input logic [63:0] x2,
                      input logic [DW-1:0] e1, input logic [DW-1:0] e2, input logic rdy);
    logic [2*DW:0] e;
    @(negedge clk);
    bus.valid_i = v;
    bus.ntt_data1_i = x1;
    bus.ntt_data2_i = x2;
    bus.ready_i = rdy;
    #1;
    cyc++;
    smp_valid = bus.valid_o;
    smp_ready = bus.ready_o;
    if (!rst_n) begin
      check("rst_outputs", {bus.valid_o, bus.last_o, bus.data2_o, bus.data1_o}, '0);
      check("rst_ready", bus.ready_o, 1'b1);
    end else begin
      check("ready_o", bus.ready_o, rdy || !bus.valid_o);
      if (hold_pend)
        check("hold_stable", {bus.valid_o, bus.last_o, bus.data2_o, bus.data1_o}, hold_val);
      if (exp_q.size() == 0) begin
        check("spurious_valid", bus.valid_o, 1'b0);
      end else if (bus.valid_o && rdy) begin
        e = exp_q.pop_front();
        check("out_pair", {bus.last_o, bus.data2_o, bus.data1_o}, e);
        out_cnt++;
        if (bus.last_o) last_cnt++;
      end
      hold_pend = bus.valid_o && !rdy;
      hold_val = {bus.valid_o, bus.last_o, bus.data2_o, bus.data1_o};
      if (v && bus.ready_o) begin
        exp_q.push_back({(pair_cnt == NP - 1), e2, e1});
        pair_cnt = (pair_cnt == NP - 1) ? 0 : pair_cnt + 1;
        accepted++;
      end
    end
  endtask

  task automatic send(input logic v, input logic [63:0] x1, input logic [63:0] x2, input logic rdy);
    step(v, x1, x2, gold(x1), gold(x2), rdy);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, $urandom(), $urandom(), '0, '0, rdy);
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) idle(1'b1);
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Asserts reset away from the clock edge, keeps random traffic on the inputs
  // while it is held, and releases it with valid_i low.
  task automatic do_reset(input int n);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    pair_cnt = 0;
    hold_pend = 1'b0;
    for (int i = 0; i < n; i++) send($urandom_range(0, 1), rand_x(), rand_x(), $urandom_range(0, 1));
    bus.valid_i = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    int lat, out0, last0, rand_acc;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.ntt_data1_i = '0;
    bus.ntt_data2_i = '0;
    bnd = '{64'd0, 64'(Q), 64'(Q - 1), 64'(-Q), 64'(-Q - 1), XMAX, XMIN};

    tbl[0] = '{64'd41902092, 64'hFFFF_FFFF_FFFF_FFFF, 32'd7, 32'd8380416};
    tbl[1] = '{64'd0, XMIN, 32'd0, gold(XMIN)};
    tbl[2] = '{64'(Q), XMAX, 32'd0, gold(XMAX)};
    tbl[3] = '{64'(Q - 1), 64'(-Q - 1), 32'd8380416, 32'd8380416};
    tbl[4] = '{64'(-Q), 64'(Q - 1), 32'd0, 32'd8380416};
    tbl[5] = '{64'(-Q - 1), 64'd0, 32'd8380416, 32'd0};
    tbl[6] = '{XMAX, 64'(Q), gold(XMAX), 32'd0};
    tbl[7] = '{XMIN, 64'(-Q), gold(XMIN), 32'd0};

    // Reset held with random inputs, then idle to catch spurious valid_o.
    for (int i = 0; i < 4; i++) send($urandom_range(0, 1), rand_x(), rand_x(), $urandom_range(0, 1));
    bus.valid_i = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Single pair: three-cycle latency.
    step(1'b1, tbl[0].x1, tbl[0].x2, tbl[0].e1, tbl[0].e2, 1'b1);
    lat = 0;
    do begin
      idle(1'b1);
      lat++;
    end while (!smp_valid && lat < 10);
    check("latency", lat, 3);
    drain(10);

    // Boundary vectors back to back.
    for (int i = 1; i < 8; i++) step(1'b1, tbl[i].x1, tbl[i].x2, tbl[i].e1, tbl[i].e2, 1'b1);
    drain(10);

    // 256-pair stream at full rate from a fresh layer.
    do_reset(2);
    out0 = out_cnt;
    last0 = last_cnt;
    for (int i = 0; i < 256; i++) send(1'b1, rand_x(), rand_x(), 1'b1);
    drain(3);
    check("stream_outputs", out_cnt - out0, 256);
    check("stream_lasts", last_cnt - last0, 2);
    check("stream_wrap", pair_cnt, 0);

    // Backpressure with valid_i held high.
    for (int i = 0; i < 10; i++) send(1'b1, rand_x(), rand_x(), 1'b1);
    for (int i = 0; i < 5; i++) send(1'b1, rand_x(), rand_x(), 1'b0);
    check("bp_ready_low", smp_ready, 1'b0);
    for (int i = 0; i < 10; i++) send(1'b1, rand_x(), rand_x(), 1'b1);
    drain(20);

    // Random traffic with a reset pulse part way through.
    rand_acc = 0;
    while (rand_acc < 10000 && cyc < 60000) begin
      lat = accepted;
      send($urandom_range(0, 3) != 0, rand_x(), rand_x(), $urandom_range(0, 3) != 0);
      rand_acc += accepted - lat;
      if (rand_acc == 5000 && accepted != lat) begin
        do_reset(3);
        for (int i = 0; i < 3; i++) idle(1'b1);
      end
    end
    check("random_accepted", rand_acc, 10000);
    drain(100);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
